// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with a fixed access latency.
// Optional macro DM_BYTE_EN: when defined, writes update only the byte lanes selected by req_be.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [3:0]      cnt_r;
  logic [3:0]      cnt_s;
  logic            accept_s;
  logic            commit_s;
  logic            err_s;
  logic [AW-1:0]   idx_s;

  logic            we_r;
  logic [31:0]     addr_r;
  logic [31:0]     wdata_r;
  logic [3:0]      be_r;

  logic            req_ready_r;
  logic            rsp_valid_r;
  logic [31:0]     rsp_rdata_r;
  logic            rsp_err_r;

  logic [31:0]     mem_r [DEPTH];

  // A request is rejected if it is not word aligned or falls beyond the last stored word.
  function automatic logic addr_error(input logic [31:0] a);
    addr_error = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  assign err_s = addr_error(addr_r);
  assign idx_s = addr_r[AW+1:2];

  // Next-state and per-cycle strobes for the request/response sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = BUSY;
          cnt_s    = CNT_INIT;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          commit_s = 1'b1;
          state_s  = RESP;
        end else begin
          cnt_s    = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and registered handshake/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_s == RESP);
      if (commit_s) begin
        rsp_err_r   <= err_s;
        rsp_rdata_r <= (err_s || we_r) ? 32'd0 : mem_r[idx_s];
      end else if ((state_r == RESP) && rsp_ready) begin
        rsp_err_r   <= 1'b0;
        rsp_rdata_r <= 32'd0;
      end else begin
        rsp_err_r   <= rsp_err_r;
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

  // Request fields are captured only on acceptance, so later input activity is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
    end else if (accept_s) begin
      we_r    <= req_we;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      be_r    <= req_be;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      be_r    <= be_r;
    end
  end

  // Storage has no reset; a write lands only on the BUSY->RESP edge, which reset prevents.
  always_ff @(posedge clk) begin
    if (commit_s && we_r && !err_s) begin
`ifdef DM_BYTE_EN
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
`else
      mem_r[idx_s] <= wdata_r;
`endif
    end
  end

`ifndef DM_BYTE_EN
  logic unused_be_s;
  assign unused_be_s = &{1'b0, be_r};
`endif

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
